// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch queue.
//   NOP_INSTR     - value shown on pop_instr while the queue is empty
//   fetch_entry_t - one buffered {pc, instr} pair (queue element type)
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between instruction fetch and the IF/ID boundary.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   push_valid/push_pc/push_instr    fetched {pc, instr} pair from fetch
//   push_ready                       accept; drives the PC register's pc_enable
//   pop_valid/pop_pc/pop_instr       head entry toward decode (0 / NOP when empty)
//   pop_ready                        decode consumes the head this cycle
//   flush                            redirect: drop every buffered entry
//   count                            occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
// XLEN must match the 32-bit fields of fetch_entry_t.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [XLEN-1:0]          push_instr,
  output logic                     push_ready,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [XLEN-1:0]          pop_pc,
  output logic [XLEN-1:0]          pop_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  logic push_fire, pop_fire;

  // push_ready looks only at state and rst_n: a full queue refuses a push
  // even if decode pops in the same cycle (no pop_ready -> pc_enable path).
  assign push_ready = (count_q != CW'(DEPTH)) && rst_n;
  assign pop_valid  = (count_q != '0);
  assign count      = count_q;

  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  // Head is read straight from the array; no bypass from the push side.
  assign pop_pc    = pop_valid ? mem_q[rd_ptr_q].pc    : '0;
  assign pop_instr = pop_valid ? mem_q[rd_ptr_q].instr : NOP_INSTR;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a flush suppresses the write so nothing lands.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) begin
      mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4): a queue model tracks the
// expected contents; each cycle the DUT outputs are compared at the falling
// edge, then new inputs are driven and the model advanced for the next edge.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            push_valid;
  logic [XLEN-1:0] push_pc, push_instr;
  logic            push_ready;
  logic            pop_valid;
  logic            pop_ready;
  logic [XLEN-1:0] pop_pc, pop_instr;
  logic            flush;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_pc(pop_pc), .pop_instr(pop_instr),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  fetch_entry_t sb_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  next_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0050_0093 ^ (pc << 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check DUT state against the model, drive inputs, advance model.
  // The pushed pc is next_pc; it advances by 4 only when the model accepts it.
  task automatic cyc(input bit pv, input bit pr, input bit fl, input bit rst_n_new);
    int  old;
    bit  popf, pushf;
    @(negedge clk);
    old = sb_q.size();
    chk("count",      32'(count),      32'(old));
    chk("push_ready", 32'(push_ready), 32'(rst_n && old != DEPTH));
    chk("pop_valid",  32'(pop_valid),  32'(old != 0));
    if (old != 0) begin
      chk("pop_pc",    pop_pc,    sb_q[0].pc);
      chk("pop_instr", pop_instr, sb_q[0].instr);
    end else begin
      chk("pop_pc_empty",    pop_pc,    32'h0);
      chk("pop_instr_empty", pop_instr, NOP_INSTR);
    end
    rst_n      = rst_n_new;
    push_valid = pv;
    push_pc    = next_pc;
    push_instr = instr_of(next_pc);
    pop_ready  = pr;
    flush      = fl;
    if (!rst_n || fl) begin
      sb_q.delete();
    end else begin
      popf  = pr && old != 0;
      pushf = pv && old != DEPTH;
      if (popf)  void'(sb_q.pop_front());
      if (pushf) begin
        sb_q.push_back('{pc: next_pc, instr: instr_of(next_pc)});
        next_pc += 32'd4;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; push_pc = '0; push_instr = '0;
    pop_ready = 1'b0; flush = 1'b0; next_pc = 32'h0;
    @(posedge clk);

    // 1. reset for 3 cycles, then a single entry (pc 0 / instr 0x0050_0093)
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    // 2. fill 0x4, 0x8, 0xC; then 0x10 offered while full (refused)
    repeat (3) cyc(1, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 1);
    // 3. drain with pops while pushing 0x10, 0x14, ... (wraps pointers)
    repeat (4) cyc(1, 1, 0, 1);
    repeat (5) cyc(0, 1, 0, 1);
    // 4. streaming: bring count to 2, then push+pop every cycle
    repeat (2) cyc(1, 0, 0, 1);
    repeat (20) cyc(1, 1, 0, 1);
    // 5. flush at count 3 together with push 0x40 and pop; then push 0x80
    cyc(1, 0, 0, 1);
    next_pc = 32'h40;
    cyc(1, 1, 1, 1);
    next_pc = 32'h80;
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    // 6. mid-operation reset at count 2
    repeat (2) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    // random traffic with occasional flush
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 30) == 0), 1'b1);
    repeat (6) cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling queue between the PC register / instruction fetch and the IF/ID boundary. Each cycle fetch presents a {pc, instr} pair. The queue buffers up to DEPTH pairs and hands them to decode in order. Its push_ready output drives the PC register's pc_enable, so a full queue freezes the PC. A redirect (taken branch, jump, or exception) flushes every buffered entry in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, width of pc and instr
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- push_valid  in  1  fetch has a valid {push_pc, push_instr} this cycle
- push_pc  in  XLEN  address of the fetched instruction
- push_instr  in  XLEN  fetched instruction word
- push_ready  out  1  queue accepts a push; wired to the PC register's pc_enable
- pop_valid  out  1  head entry is valid
- pop_ready  in  1  decode consumes the head this cycle (0 = decode stall)
- pop_pc  out  XLEN  pc of the head entry
- pop_instr  out  XLEN  instr of the head entry
- flush  in  1  redirect; discard all entries
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- **Storage.** Circular array of DEPTH entries, indexed by write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits wide. Occupancy is held in the count register.
- **Push.** Fires when push_valid && push_ready. The entry is written at wr_ptr, wr_ptr increments, and the pointer wraps modulo DEPTH naturally.
- **Pop.** Fires when pop_valid && pop_ready. rd_ptr increments with wrap.
- **Count update.**
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- **push_ready.** Equals (count != DEPTH) && rst_n. It depends only on state and rst_n, with no combinational path from pop_ready, so a full queue refuses a push even when a pop occurs in the same cycle.
- **pop_valid.** Equals (count != 0).
- **pop_pc / pop_instr.** Read combinationally from entry rd_ptr when pop_valid = 1. When the queue is empty they are 0 and NOP (32'h0000_0013).
- **No bypass.** A push into an empty queue becomes visible on pop_valid in the next cycle.
- **Flush.** Highest priority after reset.
  - On the next clock edge wr_ptr, rd_ptr and count all become 0.
  - A push or pop in the same cycle is discarded, and no entry is written.
  - Array contents need not be cleared.
- **Pushes while push_ready = 0.** Ignored; state is unchanged and nothing is dropped silently, because fetch is held by pc_enable.
- **Pop while empty.** Ignored.

## Timing
- **Reset.** rst_n is sampled on the rising clk edge. While it is low:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - push_ready = 0, pop_valid = 0
  - pop_pc = 0, pop_instr = NOP
- **Reset mid-operation.** All entries are lost, with the same effect as a flush. The first push can be accepted in the first cycle with rst_n = 1.
- **Latency.** Push-to-pop is 1 cycle minimum.
- **Throughput.** Sustains 1 push + 1 pop per cycle at any count from 1 to DEPTH−1.
- **Full.** With count = DEPTH, push_ready falls in the same cycle count reaches DEPTH. It rises again the cycle after the first pop.
- **Empty.** With count = 0, pop_valid is 0 and the outputs show the empty values.
- **Wrap-around.** Pointers roll from DEPTH−1 to 0 with no bubble.
- **Outputs.** count, push_ready and pop_valid are pure functions of registers (and of rst_n for push_ready). pop_pc and pop_instr come from an array read with no added register stage.

## Structure
- The shared package fetch_pkg holds:
  - localparam NOP_INSTR = 32'h0000_0013
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t, which is the array element type
- The block is a single module with no sub-module. The storage is an inline fetch_entry_t array written in an always_ff with synchronous reset on pointers and count only.

## Test plan
1. **Reset and single entry.** Hold rst_n low for 3 cycles, then release. Push pc 0x0000_0000 / instr 0x0050_0093 with pop_ready = 0 → next cycle pop_valid = 1, pop_pc = 0x0, pop_instr = 0x0050_0093, count = 1.
2. **Fill.** DEPTH = 4 with pop_ready = 0. Push pc 0x0, 0x4, 0x8, 0xC → push_ready = 0 once count = 4. A push of 0x10 while push_ready = 0 is ignored.
3. **Drain and wrap.** From full, set pop_ready = 1 for 4 cycles while pushing 0x10, 0x14, … from the cycle push_ready returns → pops appear in order 0x0, 0x4, 0x8, 0xC, 0x10, and pointers wrap with no bubble.
4. **Streaming.** With count = 2, hold push and pop on every cycle for 20 cycles → count stays 2 and the pc sequence increments by 4 with no gaps.
5. **Flush.** With count = 3, assert flush together with push 0x40 and pop_ready = 1 → next cycle count = 0, pop_valid = 0, pop_instr = NOP. A following push of 0x80 appears alone one cycle later.
6. **Mid-operation reset.** With count = 2, drive rst_n low for 1 cycle → count = 0, push_ready = 0 during reset and 1 the cycle after release, and no stale entries remain.
